// File: rtl/led_blink_driver_pkg.sv
// Shared definitions for the LED blink driver: FSM state encoding and
// default parameter values used by the top level and its phase timer.
package led_blink_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 4;
  localparam int DEF_TMR_W   = 27;
  localparam int DEF_ON_CYC  = 25_000_000;
  localparam int DEF_OFF_CYC = 25_000_000;

endpackage

// File: rtl/led_blink_driver_phase_timer.sv
// Loadable down-counter that times the ON and OFF phases of a blink.
// Ports:
//   clk        system clock
//   reset_p    async reset, active-high (count cleared to 0)
//   load_i     load load_val_i this cycle (takes priority over counting)
//   load_val_i value loaded into the counter
//   expired_o  high while the count is 0
// The count holds at 0 until the next load, so an idle timer stays expired.
module led_blink_driver_phase_timer
  import led_blink_driver_pkg::*;
#(
  parameter int TMR_W = DEF_TMR_W
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/led_blink_driver.sv
// LED blink driver: a trig pulse with a non-zero blink_cnt plays that many
// blinks of ON_CYC high / OFF_CYC low clocks. One request can wait in a
// pending slot while a sequence plays; further requests are dropped and
// flagged with overrun. abort cancels everything without a done pulse.
// Ports:
//   clk        system clock
//   reset_p    async reset, active-high
//   trig       single-cycle request pulse
//   blink_cnt  number of blinks, sampled when trig=1 (0 = ignore)
//   abort      synchronous cancel of current and pending sequences
//   led        registered LED drive
//   busy       high while a sequence plays
//   done       one-cycle pulse when a sequence completes
//   overrun    one-cycle pulse when a trig is dropped
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | nothing playing, led low, waiting for trig
// ST_ON   | led high, phase timer counting ON_CYC cycles
// ST_OFF  | led low, phase timer counting OFF_CYC cycles
module led_blink_driver
  import led_blink_driver_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TMR_W   = DEF_TMR_W,
  parameter int ON_CYC  = DEF_ON_CYC,
  parameter int OFF_CYC = DEF_OFF_CYC
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             trig,
  input  logic [CNT_W-1:0] blink_cnt,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_CYC - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_vld_q;
  logic [CNT_W-1:0] pend_cnt_q;
  logic             led_q;
  logic             busy_q;
  logic             done_q;
  logic             overrun_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_expired;

  logic             trig_valid;
  logic             pend_fill;
  logic             pend_drop;
  logic             last_blink;

  assign trig_valid = trig && (blink_cnt != '0);
  // A trig during a sequence (including its final OFF cycle) either takes
  // the free pending slot or is dropped when the slot is already occupied.
  assign pend_fill  = !abort && trig_valid && (state_q != ST_IDLE) && !pend_vld_q;
  assign pend_drop  = !abort && trig_valid && (state_q != ST_IDLE) && pend_vld_q;
  assign last_blink = (state_q == ST_OFF) && tmr_expired && (cnt_q == '0);

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    if (abort) begin
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_valid) begin
            tmr_load     = 1'b1;
            tmr_load_val = ON_LOAD;
          end
        end
        ST_ON: begin
          if (tmr_expired) begin
            tmr_load     = 1'b1;
            tmr_load_val = OFF_LOAD;
          end
        end
        ST_OFF: begin
          // Restart the ON phase for the next blink, or for a queued
          // sequence that chains in directly behind this one.
          if (tmr_expired && ((cnt_q != '0) || pend_vld_q || pend_fill)) begin
            tmr_load     = 1'b1;
            tmr_load_val = ON_LOAD;
          end
        end
        default: begin
          tmr_load = 1'b1;
        end
      endcase
    end
  end

  led_blink_driver_phase_timer #(
    .TMR_W(TMR_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset_p    (reset_p),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_cnt_q <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      if (abort) begin
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        pend_vld_q <= 1'b0;
        pend_cnt_q <= '0;
        led_q      <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        if (pend_drop) begin
          overrun_q <= 1'b1;
        end
        if (pend_fill) begin
          pend_vld_q <= 1'b1;
          pend_cnt_q <= blink_cnt;
        end
        case (state_q)
          ST_IDLE: begin
            if (trig_valid) begin
              state_q <= ST_ON;
              cnt_q   <= blink_cnt;
              led_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
          ST_ON: begin
            if (tmr_expired) begin
              state_q <= ST_OFF;
              cnt_q   <= cnt_q - 1'b1;
              led_q   <= 1'b0;
            end
          end
          ST_OFF: begin
            if (tmr_expired && (cnt_q != '0)) begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end else if (last_blink) begin
              done_q <= 1'b1;
              if (pend_vld_q) begin
                state_q    <= ST_ON;
                cnt_q      <= pend_cnt_q;
                pend_vld_q <= 1'b0;
                led_q      <= 1'b1;
              end else if (pend_fill) begin
                // Request arriving in the very last cycle starts at once
                // rather than sitting in the slot with nothing playing.
                state_q    <= ST_ON;
                cnt_q      <= blink_cnt;
                pend_vld_q <= 1'b0;
                led_q      <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_led_blink_driver.sv
module tb_led_blink_driver;

  localparam int CNT_W   = 4;
  localparam int TMR_W   = 27;
  localparam int ON_CYC  = 3;
  localparam int OFF_CYC = 2;
  localparam int PERIOD  = ON_CYC + OFF_CYC;

  logic             clk;
  logic             reset_p;
  logic             trig;
  logic [CNT_W-1:0] blink_cnt;
  logic             abort;
  logic             led;
  logic             busy;
  logic             done;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  // Reference model: a sequence is "active" for n*PERIOD cycles, counted by pos.
  bit m_active;
  int m_pos;
  int m_n;
  bit m_pend_v;
  int m_pend_n;
  bit m_done;
  bit m_ovr;

  int n_busy;
  int n_done;
  int n_ovr;
  logic [15:0] led_hist;

  led_blink_driver #(
    .CNT_W  (CNT_W),
    .TMR_W  (TMR_W),
    .ON_CYC (ON_CYC),
    .OFF_CYC(OFF_CYC)
  ) dut (
    .clk      (clk),
    .reset_p  (reset_p),
    .trig     (trig),
    .blink_cnt(blink_cnt),
    .abort    (abort),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_pos    = 0;
    m_n      = 0;
    m_pend_v = 0;
    m_pend_n = 0;
    m_done   = 0;
    m_ovr    = 0;
  endtask

  task automatic model_step(input bit t, input int n, input bit a);
    m_done = 0;
    m_ovr  = 0;
    if (a) begin
      m_active = 0;
      m_pend_v = 0;
    end else if (m_active) begin
      if (t && n != 0) begin
        if (m_pend_v) m_ovr = 1;
        else begin
          m_pend_v = 1;
          m_pend_n = n;
        end
      end
      m_pos++;
      if (m_pos == m_n * PERIOD) begin
        m_done = 1;
        if (m_pend_v) begin
          m_n      = m_pend_n;
          m_pos    = 0;
          m_pend_v = 0;
        end else begin
          m_active = 0;
        end
      end
    end else if (t && n != 0) begin
      m_active = 1;
      m_n      = n;
      m_pos    = 0;
    end
  endtask

  function automatic bit model_led();
    return m_active && ((m_pos % PERIOD) < ON_CYC);
  endfunction

  task automatic step(input bit t, input int n, input bit a);
    trig      = t;
    blink_cnt = CNT_W'(n);
    abort     = a;
    @(posedge clk);
    model_step(t, n, a);
    #1;
    check("led", {31'd0, led}, {31'd0, model_led()});
    check("busy", {31'd0, busy}, {31'd0, m_active});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    n_busy   += int'(busy);
    n_done   += int'(done);
    n_ovr    += int'(overrun);
    led_hist  = {led_hist[14:0], led};
    trig      = 1'b0;
    blink_cnt = '0;
    abort     = 1'b0;
  endtask

  task automatic clear_stats();
    n_busy   = 0;
    n_done   = 0;
    n_ovr    = 0;
    led_hist = '0;
  endtask

  initial begin
    trig      = 1'b0;
    blink_cnt = '0;
    abort     = 1'b0;
    reset_p   = 1'b1;
    model_reset();
    clear_stats();
    repeat (2) @(posedge clk);
    #2;
    reset_p = 1'b0;
    #1;
    check("rst_led", {31'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);

    // 1: two blinks, exact pattern and done timing
    clear_stats();
    step(1, 2, 0);
    repeat (9) step(0, 0, 0);
    check("t1_pattern", {22'd0, led_hist[9:0]}, 32'b1110011100);
    check("t1_busy_cycles", n_busy, 10);
    check("t1_no_done_yet", n_done, 0);
    step(0, 0, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    repeat (2) step(0, 0, 0);

    // 2: zero-count trig ignored
    clear_stats();
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    check("t2_busy", n_busy, 0);
    check("t2_done", n_done + n_ovr, 0);

    // 3: pending slot and overrun
    clear_stats();
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    check("t3_overrun", {31'd0, overrun}, 32'd1);
    repeat (12) step(0, 0, 0);
    check("t3_busy_cycles", n_busy, 15);
    check("t3_done_count", n_done, 2);
    check("t3_ovr_count", n_ovr, 1);
    repeat (2) step(0, 0, 0);

    // 4: abort during second ON phase, then a normal blink
    clear_stats();
    step(1, 3, 0);
    repeat (6) step(0, 0, 0);
    step(0, 0, 1);
    check("t4_abort_led", {31'd0, led}, 32'd0);
    check("t4_abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) step(0, 0, 0);
    check("t4_no_done", n_done, 0);
    clear_stats();
    step(1, 1, 0);
    repeat (5) step(0, 0, 0);
    check("t4_blink", {27'd0, led_hist[5:1]}, 32'b11100);
    check("t4_done", n_done, 1);

    // 5: abort and trig together in idle
    clear_stats();
    step(1, 2, 1);
    repeat (5) step(0, 0, 0);
    check("t5_busy", n_busy, 0);
    check("t5_ovr", n_ovr, 0);

    // 6: async reset mid-OFF
    step(1, 2, 0);
    repeat (4) step(0, 0, 0);
    check("t6_in_off", {31'd0, busy & ~led}, 32'd1);
    #2;
    reset_p = 1'b1;
    #1;
    model_reset();
    check("t6_rst_led", {31'd0, led}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_ovr", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #2;
    reset_p = 1'b0;
    clear_stats();
    step(1, 1, 0);
    repeat (6) step(0, 0, 0);
    check("t6_after_done", n_done, 1);
    check("t6_after_busy", n_busy, 5);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit t;
      bit a;
      int n;
      t = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 79) == 0);
      n = int'($urandom_range(0, 3));
      step(t, n, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
